// File: rtl/systolic_pkg.sv
// Shared state encoding and default geometry for the systolic array result drain.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        STREAM
    } drain_state_e;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_SIZE       = 4;

    // Operands skew across the array diagonally, so the last PE settles after 3*SIZE-2 cycles.
    function automatic int compute_lat_for(input int size);
        return 3 * size - 2;
    endfunction

    localparam int DEFAULT_COMPUTE_LAT = compute_lat_for(DEFAULT_SIZE);

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Waits for a SIZE x SIZE systolic array to settle, captures it row by row and streams it out
// row-major over a valid/ready handshake. Define DRAIN_ROW_END_EN to add the out_row_end flag.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SIZE        = DEFAULT_SIZE,
    parameter int COMPUTE_LAT = compute_lat_for(SIZE),
    localparam int ROW_W      = clog2_min1(SIZE),
    localparam int EW         = 2 * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [ROW_W-1:0]       row_sel,
    input  logic [EW*SIZE-1:0]     result_row,
    output logic signed [EW-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
`ifdef DRAIN_ROW_END_EN
    output logic                   out_row_end,
`endif
    output logic                   done
);

    localparam int CAP_W  = clog2_min1(SIZE + 1);
    localparam int WAIT_W = clog2_min1(COMPUTE_LAT);

    drain_state_e          state_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic [CAP_W-1:0]      cap_cnt_q;
    logic [ROW_W-1:0]      rd_row_q;
    logic [ROW_W-1:0]      rd_col_q;
    logic [ROW_W-1:0]      row_sel_q;
    logic signed [EW-1:0]  out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  done_q;
`ifdef DRAIN_ROW_END_EN
    logic                  row_end_q;
`endif

    logic [EW*SIZE-1:0]    buf_q [SIZE];

    logic                  xfer;
    logic                  cap_wr;
    logic [ROW_W-1:0]      cap_row;
    logic [ROW_W-1:0]      rd_row_d;
    logic [ROW_W-1:0]      rd_col_d;
    logic [EW*SIZE-1:0]    rd_line_d;
    logic signed [EW-1:0]  out_data_d;
    logic signed [EW-1:0]  first_elem;

    // NOTE: combinational logic uses blocking '='; every clocked register below uses '<='.
    always_comb begin
        // NOTE: each signal gets a default before any branch so no latch can be inferred.
        xfer    = out_valid_q && out_ready;
        cap_wr  = (state_q == CAPTURE) && (cap_cnt_q != '0);
        cap_row = ROW_W'(cap_cnt_q - CAP_W'(1));

        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q + ROW_W'(1);
        if (rd_col_q == ROW_W'(SIZE - 1)) begin
            rd_row_d = rd_row_q + ROW_W'(1);
            rd_col_d = '0;
        end

        rd_line_d  = buf_q[rd_row_d];
        out_data_d = '0;
        for (int c = 0; c < SIZE; c++) begin
            if (rd_col_d == ROW_W'(c)) begin
                out_data_d = rd_line_d[c*EW +: EW];
            end
        end

        // With a single row, element (0,0) is still on result_row when STREAM is entered.
        first_elem = (SIZE == 1) ? result_row[EW-1:0] : buf_q[0][EW-1:0];
    end

    // NOTE: the buffer carries no reset; every row is rewritten in CAPTURE before it is read.
    always_ff @(posedge clk) begin
        if (cap_wr) begin
            buf_q[cap_row] <= result_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            cap_cnt_q   <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            row_sel_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef DRAIN_ROW_END_EN
            row_end_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= WAIT_W'(COMPUTE_LAT - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q   <= CAPTURE;
                        cap_cnt_q <= '0;
                        row_sel_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
                    end
                end
                CAPTURE: begin
                    // cap_cnt_q = k drives row k and stores row k-1 returned by the array.
                    if (cap_cnt_q == CAP_W'(SIZE)) begin
                        state_q     <= STREAM;
                        cap_cnt_q   <= '0;
                        rd_row_q    <= '0;
                        rd_col_q    <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= first_elem;
                        out_last_q  <= (SIZE == 1);
`ifdef DRAIN_ROW_END_EN
                        row_end_q   <= (SIZE == 1);
`endif
                    end else begin
                        cap_cnt_q <= cap_cnt_q + CAP_W'(1);
                        row_sel_q <= (cap_cnt_q < CAP_W'(SIZE - 1))
                                   ? ROW_W'(cap_cnt_q) + ROW_W'(1) : '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            rd_row_q    <= '0;
                            rd_col_q    <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            done_q      <= 1'b1;
`ifdef DRAIN_ROW_END_EN
                            row_end_q   <= 1'b0;
`endif
                        end else begin
                            rd_row_q    <= rd_row_d;
                            rd_col_q    <= rd_col_d;
                            out_data_q  <= out_data_d;
                            out_last_q  <= (rd_row_d == ROW_W'(SIZE - 1))
                                        && (rd_col_d == ROW_W'(SIZE - 1));
`ifdef DRAIN_ROW_END_EN
                            row_end_q   <= (rd_col_d == ROW_W'(SIZE - 1));
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign row_sel   = row_sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
`ifdef DRAIN_ROW_END_EN
    assign out_row_end = row_end_q;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized bench for systolic_result_drain against a row-major matrix model of the array.
module tb_systolic_result_drain;

    localparam int DW   = 8;
    localparam int SZ   = 4;
    localparam int CL   = 3 * SZ - 2;
    localparam int EW   = 2 * DW;
    localparam int NEL  = SZ * SZ;
    localparam int RW   = $clog2(SZ);
    localparam int FIRST_VALID = 1 + CL + SZ + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               out_ready;
    logic [RW-1:0]      row_sel;
    logic [EW*SZ-1:0]   result_row;
    logic signed [EW-1:0] out_data;
    logic               out_valid;
    logic               out_last;
    logic               busy;
    logic               done;
`ifdef DRAIN_ROW_END_EN
    logic               out_row_end;
`endif

    int errors = 0;
    int checks = 0;

    int model_mat [SZ][SZ];

    int             obs_data[$];
    bit             obs_last[$];
    bit             obs_rend[$];
    logic [RW-1:0]  obs_rowsel[$];
    bit             obs_busy[$];
    bit             obs_valid[$];
    int             done_cycle;
    int             done_count;
    int             stall_bad;
    bit             timed_out;
    bit             rst_fired;
    bit             post_rst_valid;
    bit             post_rst_busy;
    logic [EW-1:0]  post_rst_data;

    systolic_result_drain #(
        .DATA_WIDTH (DW),
        .SIZE       (SZ),
        .COMPUTE_LAT(CL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .row_sel    (row_sel),
        .result_row (result_row),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
`ifdef DRAIN_ROW_END_EN
        .out_row_end(out_row_end),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    // Array model: returns the row addressed by the previous cycle's row_sel.
    always @(posedge clk) begin
        for (int c = 0; c < SZ; c++) begin
            result_row[c*EW +: EW] <= EW'(model_mat[row_sel][c]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                model_mat[r][c] = 16 * r + c + 1;
    endtask

    task automatic fill_random();
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                model_mat[r][c] = int'($signed(EW'($urandom)));
    endtask

    // Drives one operation from the start pulse and records what the DUT does each cycle.
    task automatic run_op(input bit toggle_ready, input bit extra_start, input int rst_at);
        int cyc;
        int s_cyc;
        bit fin;
        bit prev_valid;
        bit prev_ready;
        logic [EW-1:0] prev_data;
        obs_data.delete(); obs_last.delete(); obs_rend.delete();
        obs_rowsel.delete(); obs_busy.delete(); obs_valid.delete();
        done_cycle = -1; done_count = 0; stall_bad = 0; timed_out = 0; rst_fired = 0;
        post_rst_valid = 0; post_rst_busy = 0; post_rst_data = '0;
        prev_valid = 0; prev_ready = 0; prev_data = '0; s_cyc = 0; fin = 0;
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!fin) begin
            obs_busy.push_back(busy);
            obs_rowsel.push_back(row_sel);
            obs_valid.push_back(out_valid);
            if (done) begin
                done_cycle = cyc;
                done_count++;
                fin = 1;
            end else begin
                if (out_valid) begin
                    out_ready = !toggle_ready || (s_cyc % 4 == 0) || (s_cyc % 4 == 3);
                    if (prev_valid && !prev_ready && out_data !== prev_data) stall_bad++;
                    start = extra_start && (s_cyc == 0);
                    if (rst_at >= 0 && obs_data.size() == rst_at) begin
                        rst = 1'b1;
                        rst_fired = 1;
                    end else if (out_ready) begin
                        obs_data.push_back(int'($signed(out_data)));
                        obs_last.push_back(out_last);
`ifdef DRAIN_ROW_END_EN
                        obs_rend.push_back(out_row_end);
`else
                        obs_rend.push_back(1'b0);
`endif
                    end
                    s_cyc++;
                end else begin
                    out_ready = 1'b1;
                    start = extra_start && (cyc == 5);
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_data  = out_data;
                tick();
                start = 1'b0;
                cyc++;
                if (rst_fired) begin
                    rst = 1'b0;
                    post_rst_valid = out_valid;
                    post_rst_busy  = busy;
                    post_rst_data  = out_data;
                    repeat (40) begin
                        if (done) done_count++;
                        tick();
                    end
                    fin = 1;
                end else if (cyc > 300) begin
                    timed_out = 1;
                    fin = 1;
                end
            end
        end
    endtask

    // Compares the recorded stream with the model matrix in row-major order.
    task automatic check_stream(input string tag);
        int exp_q[$];
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                exp_q.push_back(model_mat[r][c]);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s_timeout: no done within cycle budget", tag);
        end
        checks++;
        if (obs_data.size() != NEL) begin
            errors++;
            $display("FAIL %s_count: got %0d transfers, want %0d", tag, obs_data.size(), NEL);
        end
        for (int i = 0; i < NEL && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == NEL - 1)) begin
                errors++;
                $display("FAIL %s_elem%0d: got data=%0d last=%0b, want data=%0d last=%0b",
                         tag, i, obs_data[i], obs_last[i], exp_q[i], (i == NEL - 1));
            end
        end
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d, want 1", tag, done_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (row_sel !== '0 || out_data !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got row_sel=%0d data=%0h valid=%0b last=%0b busy=%0b done=%0b, want all 0",
                     row_sel, out_data, out_valid, out_last, busy, done);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_priority: got busy=%0b, want 0", busy);
        end
    endtask

    task automatic test_basic();
        bit bad;
        fill_pattern();
        run_op(1'b0, 1'b0, -1);
        checks++;
        if (obs_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_rise: got %0b, want 1", obs_busy[0]);
        end
        bad = 0;
        for (int k = 1; k <= obs_rowsel.size(); k++) begin
            int exp_rs;
            exp_rs = (k >= 1 + CL && k < 1 + CL + SZ) ? k - (1 + CL) : 0;
            if (!bad && obs_rowsel[k-1] !== RW'(exp_rs)) begin
                bad = 1;
                $display("FAIL basic_row_sel: cycle %0d got %0d, want %0d", k, obs_rowsel[k-1], exp_rs);
            end
        end
        checks++;
        if (bad) errors++;
        bad = 0;
        for (int k = 1; k <= FIRST_VALID && k <= obs_valid.size(); k++) begin
            if (!bad && obs_valid[k-1] !== (k == FIRST_VALID)) begin
                bad = 1;
                $display("FAIL basic_valid: cycle %0d got %0b, want %0b", k, obs_valid[k-1], (k == FIRST_VALID));
            end
        end
        checks++;
        if (bad) errors++;
        check_stream("basic");
        checks++;
        if (done_cycle != FIRST_VALID + NEL) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d, want %0d", done_cycle, FIRST_VALID + NEL);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%0b busy=%0b, want 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        int n;
        int s;
        int exp_done;
        fill_random();
        run_op(1'b1, 1'b0, -1);
        check_stream("stall");
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d changes under stall, want 0", stall_bad);
        end
        n = 0;
        exp_done = -1;
        for (s = 0; s < 200 && exp_done < 0; s++) begin
            if (s % 4 == 0 || s % 4 == 3) n++;
            if (n == NEL) exp_done = FIRST_VALID + s + 1;
        end
        checks++;
        if (done_cycle != exp_done) begin
            errors++;
            $display("FAIL stall_done_cycle: got %0d, want %0d", done_cycle, exp_done);
        end
    endtask

    task automatic test_negative();
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                model_mat[r][c] = -300;
        run_op(1'b0, 1'b0, -1);
        check_stream("negative");
        checks++;
        if (obs_data.size() == 0 || EW'(obs_data[0]) !== 16'hFED4) begin
            errors++;
            $display("FAIL negative_raw: got %0h, want fed4", obs_data.size() ? EW'(obs_data[0]) : '0);
        end
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_op(1'b0, 1'b1, -1);
        check_stream("start_ignored");
        checks++;
        if (done_cycle != FIRST_VALID + NEL) begin
            errors++;
            $display("FAIL start_ignored_done_cycle: got %0d, want %0d", done_cycle, FIRST_VALID + NEL);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_idle: got busy=%0b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_op(1'b0, 1'b0, -1);
        check_stream("b2b_first");
        fill_random();
        run_op(1'b0, 1'b0, -1);
        checks++;
        if (obs_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start_in_done: got busy=%0b, want 1", obs_busy[0]);
        end
        check_stream("b2b_second");
    endtask

    task automatic test_reset_mid();
        fill_random();
        run_op(1'b0, 1'b0, 4);
        checks++;
        if (post_rst_valid !== 1'b0 || post_rst_busy !== 1'b0 || post_rst_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got valid=%0b busy=%0b data=%0h, want 0 0 0",
                     post_rst_valid, post_rst_busy, post_rst_data);
        end
        checks++;
        if (done_count != 0 || obs_data.size() != 4) begin
            errors++;
            $display("FAIL mid_reset_abandon: got done=%0d transfers=%0d, want 0 4", done_count, obs_data.size());
        end
        fill_random();
        run_op(1'b0, 1'b0, -1);
        check_stream("after_reset");
    endtask

`ifdef DRAIN_ROW_END_EN
    task automatic test_row_end();
        fill_random();
        run_op(1'b1, 1'b0, -1);
        for (int i = 0; i < obs_rend.size(); i++) begin
            checks++;
            if (obs_rend[i] !== ((i + 1) % SZ == 0)) begin
                errors++;
                $display("FAIL row_end_elem%0d: got %0b, want %0b", i + 1, obs_rend[i], ((i + 1) % SZ == 0));
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_negative();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef DRAIN_ROW_END_EN
        test_row_end();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
